// File: rtl/counter_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// counter_seq_pkg
// Shared definitions for the counter sequencer slice:
//   - command opcode encodings carried on cmd_op
//   - controller state enumeration
//   - bit positions of the START command flags inside cmd_data
// -----------------------------------------------------------------------------
package counter_seq_pkg;

  // Command opcodes
  localparam logic [1:0] OP_SET_LIMIT    = 2'b00;
  localparam logic [1:0] OP_SET_PRESCALE = 2'b01;
  localparam logic [1:0] OP_START        = 2'b10;
  localparam logic [1:0] OP_STOP         = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // START flag positions within cmd_data
  localparam int START_ONE_SHOT_BIT = 0;
  localparam int START_CLEAR_BIT    = 1;

endpackage

// File: rtl/counter_sequencer_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides the clock into a count-enable tick: while enabled, the internal
// counter runs 0..P and the tick fires on the cycle it reaches P, after which
// the counter returns to 0. One tick every P+1 enabled clocks.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_prescale   divide value P
//   i_restart    force the counter back to 0 (START accepted)
//   i_enable     counter advances only while high; holds otherwise
//   o_tick       decoded from registered count and registered prescale
// -----------------------------------------------------------------------------
module tick_prescaler
  import counter_seq_pkg::*;
#(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PRE_W-1:0] i_prescale,
  input  logic             i_restart,
  input  logic             i_enable,
  output logic             o_tick
);

  logic [PRE_W-1:0] r_pre_cnt;

  // >= rather than == so that lowering P below the current count ticks on
  // the very next cycle instead of running all the way round the modulus.
  assign o_tick = i_enable & (r_pre_cnt >= i_prescale);

  // Prescale counter: restart wins, then wrap on tick, then advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt <= {PRE_W{1'b0}};
    end else if (i_restart) begin
      r_pre_cnt <= {PRE_W{1'b0}};
    end else if (o_tick) begin
      r_pre_cnt <= {PRE_W{1'b0}};
    end else if (i_enable) begin
      r_pre_cnt <= r_pre_cnt + PRE_W'(1);
    end else begin
      r_pre_cnt <= r_pre_cnt;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
// Command-driven controller for the up-counter datapath. Sequences start,
// stop and resume, applies a programmable prescaled count enable and a
// programmable terminal value, and reports wrap / one-shot completion.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_cmd_valid    command present
//   o_cmd_ready    command accepted when valid & ready at posedge (low in DONE)
//   i_cmd_op       00 SET_LIMIT, 01 SET_PRESCALE, 10 START, 11 STOP
//   i_cmd_data     SET_*: value; START: bit0 one_shot, bit1 clear
//   o_count        current counter value
//   o_running      high while in RUN
//   o_wrap         1-cycle pulse on free-run terminal tick (count L->0)
//   o_done         1-cycle pulse on one-shot terminal tick
// -----------------------------------------------------------------------------
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               PRE_W       = 8,
  parameter logic [WIDTH-1:0] RESET_LIMIT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [7:0]       i_cmd_data,
  output logic [WIDTH-1:0] o_count,
  output logic             o_running,
  output logic             o_wrap,
  output logic             o_done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_limit;
  logic [WIDTH-1:0] r_shadow_limit;
  logic [PRE_W-1:0] r_prescale;
  logic             r_one_shot;
  logic             r_running;
  logic             r_wrap;
  logic             r_done;
  logic             r_cmd_ready;

  logic             w_accept;
  logic             w_op_set_limit;
  logic             w_op_set_prescale;
  logic             w_op_start;
  logic             w_op_stop;
  logic             w_enable;
  logic             w_tick;
  logic [WIDTH-1:0] w_cmd_value;
  logic [WIDTH-1:0] w_shadow_next;

  assign w_accept          = i_cmd_valid & r_cmd_ready;
  assign w_op_set_limit    = w_accept & (i_cmd_op == OP_SET_LIMIT);
  assign w_op_set_prescale = w_accept & (i_cmd_op == OP_SET_PRESCALE);
  assign w_op_start        = w_accept & (i_cmd_op == OP_START);
  assign w_op_stop         = w_accept & (i_cmd_op == OP_STOP);
  assign w_cmd_value       = WIDTH'(i_cmd_data);

  // A STOP freezes the prescaler in the same cycle so pre_cnt holds.
  assign w_enable = (r_state == ST_RUN) & ~w_op_stop;

  // A SET_LIMIT landing on a wrap cycle is picked up by that same wrap.
  assign w_shadow_next = w_op_set_limit ? w_cmd_value : r_shadow_limit;

  tick_prescaler #(
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_prescale(r_prescale),
    .i_restart (w_op_start),
    .i_enable  (w_enable),
    .o_tick    (w_tick)
  );

  // Controller FSM with limit/shadow/prescale registers, count and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_count        <= {WIDTH{1'b0}};
      r_limit        <= RESET_LIMIT;
      r_shadow_limit <= RESET_LIMIT;
      r_prescale     <= {PRE_W{1'b0}};
      r_one_shot     <= 1'b0;
      r_running      <= 1'b0;
      r_wrap         <= 1'b0;
      r_done         <= 1'b0;
      r_cmd_ready    <= 1'b1;
    end else begin
      r_wrap         <= 1'b0;
      r_done         <= 1'b0;
      r_shadow_limit <= w_shadow_next;
      if (w_op_set_prescale) begin
        r_prescale <= PRE_W'(i_cmd_data);
      end
      case (r_state)
        ST_IDLE, ST_RUN: begin
          r_cmd_ready <= 1'b1;
          if (w_op_set_limit && (r_state == ST_IDLE)) begin
            r_limit <= w_cmd_value;
          end
          if (w_op_start) begin
            // START and STOP win over a coincident tick; SET_* do not.
            r_state    <= ST_RUN;
            r_running  <= 1'b1;
            r_one_shot <= i_cmd_data[START_ONE_SHOT_BIT];
            if (i_cmd_data[START_CLEAR_BIT]) begin
              r_count <= {WIDTH{1'b0}};
            end
          end else if (w_op_stop) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end else if (w_tick) begin
            if (r_count != r_limit) begin
              // Also covers count above limit: rolls over 2**WIDTH-1 -> 0 silently.
              r_count <= r_count + WIDTH'(1);
            end else if (r_one_shot) begin
              r_done      <= 1'b1;
              r_state     <= ST_DONE;
              r_running   <= 1'b0;
              r_cmd_ready <= 1'b0;
            end else begin
              r_count <= {WIDTH{1'b0}};
              r_wrap  <= 1'b1;
              r_limit <= w_shadow_next;
            end
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_running   <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_running   <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_count     = r_count;
  assign o_running   = r_running;
  assign o_wrap      = r_wrap;
  assign o_done      = r_done;

endmodule

// File: tb/tb_counter_sequencer.sv
// -----------------------------------------------------------------------------
// tb_counter_sequencer
// Directed tests for counter_sequencer with hand-computed expected values.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_counter_sequencer;

  localparam logic [1:0] OP_SL = 2'b00;
  localparam logic [1:0] OP_SP = 2'b01;
  localparam logic [1:0] OP_GO = 2'b10;
  localparam logic [1:0] OP_ST = 2'b11;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst_n = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic [1:0] i_cmd_op = 2'b00;
  logic [7:0] i_cmd_data = 8'd0;
  logic       o_cmd_ready;
  logic [7:0] o_count;
  logic       o_running;
  logic       o_wrap;
  logic       o_done;

  int checks = 0;
  int errors = 0;

  counter_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_op   (i_cmd_op),
    .i_cmd_data (i_cmd_data),
    .o_count    (o_count),
    .o_running  (o_running),
    .o_wrap     (o_wrap),
    .o_done     (o_done)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] data);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_data  = data;
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
    i_cmd_data  = 8'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_count !== 8'd0 || o_running !== 1'b0 || o_cmd_ready !== 1'b1 ||
        o_wrap !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d run=%b rdy=%b wrap=%b done=%b, expected 0 0 1 0 0",
               o_count, o_running, o_cmd_ready, o_wrap, o_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // limit 3, prescale 0, free-run with clear: 0,1,2,3,0,...
  task automatic test_free_run();
    cmd(OP_SL, 8'd3);
    cmd(OP_SP, 8'd0);
    cmd(OP_GO, 8'h02);
    checks++;
    if (o_count !== 8'd0 || o_running !== 1'b1) begin
      errors++;
      $display("FAIL free_run_start: count=%0d run=%b, expected 0 1", o_count, o_running);
    end
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (o_count !== 8'(i % 4) || o_wrap !== (i % 4 == 0)) begin
        errors++;
        $display("FAIL free_run[%0d]: count=%0d wrap=%b, expected %0d %b",
                 i, o_count, o_wrap, i % 4, (i % 4 == 0));
      end
    end
    cmd(OP_ST, 8'd0);
  endtask

  // prescale 2, limit 1, one-shot with clear: count=1 at N+3, done at N+6
  task automatic test_one_shot();
    logic [7:0] exp_cnt;
    cmd(OP_SP, 8'd2);
    cmd(OP_SL, 8'd1);
    cmd(OP_GO, 8'h03);
    for (int i = 1; i <= 7; i++) begin
      step();
      exp_cnt = (i < 3) ? 8'd0 : 8'd1;
      checks++;
      if (o_count !== exp_cnt || o_done !== (i == 6) || o_cmd_ready !== (i != 6) ||
          o_running !== (i < 6) || o_wrap !== 1'b0) begin
        errors++;
        $display("FAIL one_shot[%0d]: count=%0d done=%b rdy=%b run=%b wrap=%b, expected %0d %b %b %b 0",
                 i, o_count, o_done, o_cmd_ready, o_running, o_wrap,
                 exp_cnt, (i == 6), (i != 6), (i < 6));
      end
    end
  endtask

  // limit 3 running; SET_LIMIT 5 mid-period takes effect only after the wrap
  task automatic test_shadow_limit();
    logic [7:0] exp_cnt [0:10];
    logic       exp_wrap;
    exp_cnt = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
    cmd(OP_SP, 8'd0);
    cmd(OP_SL, 8'd3);
    cmd(OP_GO, 8'h02);
    step();
    cmd(OP_SL, 8'd5);
    checks++;
    if (o_count !== 8'd2) begin
      errors++;
      $display("FAIL shadow_set_tick: count=%0d, expected 2", o_count);
    end
    for (int i = 3; i <= 10; i++) begin
      step();
      exp_wrap = (i == 4) || (i == 10);
      checks++;
      if (o_count !== exp_cnt[i] || o_wrap !== exp_wrap) begin
        errors++;
        $display("FAIL shadow_limit[%0d]: count=%0d wrap=%b, expected %0d %b",
                 i, o_count, o_wrap, exp_cnt[i], exp_wrap);
      end
    end
    cmd(OP_ST, 8'd0);
  endtask

  // STOP on the terminal tick suppresses it; resume wraps on the next tick
  task automatic test_stop_at_terminal();
    cmd(OP_SL, 8'd3);
    cmd(OP_GO, 8'h02);
    step();
    step();
    step();
    cmd(OP_ST, 8'd0);
    checks++;
    if (o_count !== 8'd3 || o_wrap !== 1'b0 || o_running !== 1'b0) begin
      errors++;
      $display("FAIL stop_terminal: count=%0d wrap=%b run=%b, expected 3 0 0",
               o_count, o_wrap, o_running);
    end
    step();
    checks++;
    if (o_count !== 8'd3 || o_wrap !== 1'b0) begin
      errors++;
      $display("FAIL stop_hold: count=%0d wrap=%b, expected 3 0", o_count, o_wrap);
    end
    cmd(OP_GO, 8'h00);
    checks++;
    if (o_count !== 8'd3 || o_running !== 1'b1) begin
      errors++;
      $display("FAIL resume_start: count=%0d run=%b, expected 3 1", o_count, o_running);
    end
    step();
    checks++;
    if (o_count !== 8'd0 || o_wrap !== 1'b1) begin
      errors++;
      $display("FAIL resume_wrap: count=%0d wrap=%b, expected 0 1", o_count, o_wrap);
    end
    cmd(OP_ST, 8'd0);
  endtask

  // limit 0: every tick is terminal, wrap every cycle; STOP drops it
  task automatic test_limit_zero();
    cmd(OP_SL, 8'd0);
    cmd(OP_GO, 8'h02);
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (o_count !== 8'd0 || o_wrap !== 1'b1) begin
        errors++;
        $display("FAIL limit_zero[%0d]: count=%0d wrap=%b, expected 0 1", i, o_count, o_wrap);
      end
    end
    cmd(OP_ST, 8'd0);
    checks++;
    if (o_wrap !== 1'b0 || o_running !== 1'b0) begin
      errors++;
      $display("FAIL limit_zero_stop: wrap=%b run=%b, expected 0 0", o_wrap, o_running);
    end
  endtask

  // Lowering P below pre_cnt ticks on the next cycle
  task automatic test_prescale_clamp();
    cmd(OP_SL, 8'd200);
    cmd(OP_SP, 8'd5);
    cmd(OP_GO, 8'h02);
    step();
    step();
    step();
    cmd(OP_SP, 8'd1);
    checks++;
    if (o_count !== 8'd0) begin
      errors++;
      $display("FAIL clamp_before: count=%0d, expected 0", o_count);
    end
    step();
    checks++;
    if (o_count !== 8'd1) begin
      errors++;
      $display("FAIL clamp_tick: count=%0d, expected 1", o_count);
    end
    step();
    step();
    checks++;
    if (o_count !== 8'd2) begin
      errors++;
      $display("FAIL clamp_period: count=%0d, expected 2", o_count);
    end
    cmd(OP_ST, 8'd0);
  endtask

  // Count 5 with limit lowered to 2: rolls 255->0 silently, then wraps at 2
  task automatic test_count_above_limit();
    logic [7:0] exp_cnt;
    cmd(OP_SP, 8'd0);
    cmd(OP_SL, 8'd5);
    cmd(OP_GO, 8'h03);
    for (int i = 1; i <= 7; i++) step();
    checks++;
    if (o_count !== 8'd5 || o_running !== 1'b0 || o_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL above_setup: count=%0d run=%b rdy=%b, expected 5 0 1",
               o_count, o_running, o_cmd_ready);
    end
    cmd(OP_SL, 8'd2);
    cmd(OP_GO, 8'h00);
    for (int i = 1; i <= 254; i++) begin
      step();
      exp_cnt = (i == 254) ? 8'd0 : 8'((5 + i) % 256);
      checks++;
      if (o_count !== exp_cnt || o_wrap !== (i == 254)) begin
        errors++;
        $display("FAIL above_limit[%0d]: count=%0d wrap=%b, expected %0d %b",
                 i, o_count, o_wrap, exp_cnt, (i == 254));
      end
    end
  endtask

  // Reset with the clock stopped clears everything immediately
  task automatic test_reset_mid_run();
    step();
    @(negedge clk);
    #1;
    clk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if (o_count !== 8'd0 || o_running !== 1'b0 || o_cmd_ready !== 1'b1 ||
        o_wrap !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: count=%0d run=%b rdy=%b wrap=%b done=%b, expected 0 0 1 0 0",
               o_count, o_running, o_cmd_ready, o_wrap, o_done);
    end
    #10;
    rst_n = 1'b1;
    #3;
    clk_en = 1'b1;
    step();
  endtask

  // After reset: limit 255, prescale 0 -> wrap after 256 clocks
  task automatic test_reset_limit();
    cmd(OP_GO, 8'h02);
    for (int i = 1; i <= 256; i++) begin
      step();
      checks++;
      if (o_count !== 8'(i % 256) || o_wrap !== (i == 256)) begin
        errors++;
        $display("FAIL reset_limit[%0d]: count=%0d wrap=%b, expected %0d %b",
                 i, o_count, o_wrap, i % 256, (i == 256));
      end
    end
    cmd(OP_ST, 8'd0);
  endtask

  initial begin
    #2;
    test_reset();
    test_free_run();
    test_one_shot();
    test_shadow_limit();
    test_stop_at_terminal();
    test_limit_zero();
    test_prescale_clamp();
    test_count_above_limit();
    test_reset_mid_run();
    test_reset_limit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
